// File: rtl/gbuf_tile_reader.sv
// Read initiator for the single-port global buffer: walks a 2-D tile in row-major order and
// streams the words out over valid/ready, hiding the GB's 1-cycle read latency with a 2-deep FIFO.
module gbuf_tile_reader #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DIM_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [ADDR_BITS-1:0] base_addr_i,
    input  logic [DIM_BITS-1:0]  rows_i,
    input  logic [DIM_BITS-1:0]  cols_i,
    input  logic [DIM_BITS-1:0]  stride_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 gb_wr_en_o,
    output logic [ADDR_BITS-1:0] gb_index_o,
    output logic [DATA_BITS-1:0] gb_data_in_o,
    input  logic [DATA_BITS-1:0] gb_data_out_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DATA_BITS-1:0] out_data_o,
    output logic                 out_last_o,
    output logic                 out_row_last_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e               state_q;
    logic [ADDR_BITS-1:0] row_start_q;
    logic [DIM_BITS-1:0]  col_q, row_q;
    logic [DIM_BITS-1:0]  rows_q, cols_q, stride_q;
    logic [ADDR_BITS-1:0] idx_q;
    logic                 inflight_q, infl_last_q, infl_row_last_q;

    logic [DATA_BITS-1:0] fifo_data_q [2];
    logic                 fifo_last_q [2];
    logic                 fifo_rlast_q [2];
    logic                 rd_ptr_q, wr_ptr_q;
    logic [1:0]           count_q;

    logic                 pop, issue, col_last, row_last;
    logic [2:0]           occ;
    logic [ADDR_BITS-1:0] cur_addr;

    always_comb begin
        out_valid_o = (count_q != 2'd0);
        pop         = out_valid_o & out_ready_i;
        // Slots committed after this cycle's pop: stored words plus the read still in flight.
        occ         = 3'(count_q) + 3'(inflight_q) - 3'(pop);
        issue       = (state_q == StIssue) && (occ < 3'd2);
        col_last    = (col_q == cols_q - DIM_BITS'(1));
        row_last    = (row_q == rows_q - DIM_BITS'(1));
        cur_addr    = row_start_q + ADDR_BITS'(col_q);
        gb_index_o  = issue ? cur_addr : idx_q;
    end

    assign out_data_o     = fifo_data_q[rd_ptr_q];
    assign out_last_o     = fifo_last_q[rd_ptr_q];
    assign out_row_last_o = fifo_rlast_q[rd_ptr_q];
    assign busy_o         = (state_q != StIdle);
    assign done_o         = (state_q == StDone);
    assign gb_wr_en_o     = 1'b0;
    assign gb_data_in_o   = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            row_start_q     <= '0;
            col_q           <= '0;
            row_q           <= '0;
            rows_q          <= '0;
            cols_q          <= '0;
            stride_q        <= '0;
            idx_q           <= '0;
            inflight_q      <= 1'b0;
            infl_last_q     <= 1'b0;
            infl_row_last_q <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i]  <= '0;
                fifo_last_q[i]  <= 1'b0;
                fifo_rlast_q[i] <= 1'b0;
            end
        end else begin
            idx_q           <= gb_index_o;
            inflight_q      <= issue;
            infl_row_last_q <= issue & col_last;
            infl_last_q     <= issue & col_last & row_last;

            // The word addressed last cycle is on gb_data_out now.
            if (inflight_q) begin
                fifo_data_q[wr_ptr_q]  <= gb_data_out_i;
                fifo_last_q[wr_ptr_q]  <= infl_last_q;
                fifo_rlast_q[wr_ptr_q] <= infl_row_last_q;
                wr_ptr_q               <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(inflight_q) - 2'(pop);

            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        row_start_q <= base_addr_i;
                        rows_q      <= rows_i;
                        cols_q      <= cols_i;
                        stride_q    <= stride_i;
                        col_q       <= '0;
                        row_q       <= '0;
                        if (rows_i == '0 || cols_i == '0) begin
                            state_q <= StDone;
                        end else begin
                            state_q <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (issue) begin
                        if (col_last) begin
                            col_q       <= '0;
                            row_q       <= row_q + DIM_BITS'(1);
                            row_start_q <= row_start_q + ADDR_BITS'(stride_q);
                            if (row_last) begin
                                state_q <= StDrain;
                            end
                        end else begin
                            col_q <= col_q + DIM_BITS'(1);
                        end
                    end
                end
                StDrain: begin
                    // occ==0 means the final element handshakes this cycle.
                    if (occ == 3'd0) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gbuf_tile_reader.sv
// Bench for gbuf_tile_reader: GB memory model, queue-based stream model with a per-cycle
// compare process, and directed tiles with literal cycle-by-cycle expectations.
module tb_gbuf_tile_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] base = 8'h00;
    logic [3:0] rows = 4'd0, cols = 4'd0, stride = 4'd0;
    logic       out_ready = 1'b0;
    logic       busy, done, gb_wr_en, out_valid, out_last, out_row_last;
    logic [7:0] gb_index, gb_data_in, gb_data_out, out_data;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       row_last;
    } elem_t;

    elem_t       exp_q [$];
    logic        rand_mode = 1'b0;
    logic [15:0] lfsr = 16'hACE1;

    gbuf_tile_reader #(.ADDR_BITS(8), .DATA_BITS(8), .DIM_BITS(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .base_addr_i   (base),
        .rows_i        (rows),
        .cols_i        (cols),
        .stride_i      (stride),
        .busy_o        (busy),
        .done_o        (done),
        .gb_wr_en_o    (gb_wr_en),
        .gb_index_o    (gb_index),
        .gb_data_in_o  (gb_data_in),
        .gb_data_out_i (gb_data_out),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_last_o    (out_last),
        .out_row_last_o(out_row_last)
    );

    always #5 clk = ~clk;

    // GB contents: mem[i] = i+1 truncated to 8 bits.
    function automatic logic [7:0] mem_word(input logic [7:0] a);
        return a + 8'd1;
    endfunction

    always @(posedge clk) gb_data_out <= mem_word(gb_index);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_tile(input logic [7:0] b, input int r, input int c, input int s);
        elem_t e;
        for (int i = 0; i < r; i++) begin
            for (int j = 0; j < c; j++) begin
                e.data     = mem_word(8'(b + i * s + j));
                e.row_last = (j == c - 1);
                e.last     = (j == c - 1) && (i == r - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Called at posedge+1 of cycle 0; returns at posedge+1 of cycle 1.
    task automatic start_tile(input logic [7:0] b, input logic [3:0] r, input logic [3:0] c,
                              input logic [3:0] s);
        model_tile(b, int'(r), int'(c), int'(s));
        base   = b;
        rows   = r;
        cols   = c;
        stride = s;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic run_count(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) pulses++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_mode) begin
                lfsr      = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                out_ready = lfsr[0];
            end
        end
    end

    // Stream compare process: every handshake against the model, stall stability, done timing.
    logic  prev_stall = 1'b0;
    logic  prev_last_hs = 1'b0;
    elem_t prev_elem;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall   = 1'b0;
            prev_last_hs = 1'b0;
        end else begin
            check("gb_wr_en", 32'(gb_wr_en), 32'd0);
            check("gb_data_in", 32'(gb_data_in), 32'd0);
            if (prev_last_hs) check("done_after_last", 32'(done), 32'd1);
            if (prev_stall) begin
                check("valid_held", 32'(out_valid), 32'd1);
                check("stall_stable", 32'({out_data, out_last, out_row_last}), 32'(prev_elem));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_elem: got=%0h want=none", out_data);
                end else begin
                    check("stream", 32'({out_data, out_last, out_row_last}),
                          32'(exp_q.pop_front()));
                end
            end
            prev_stall   = out_valid && !out_ready;
            prev_elem    = {out_data, out_last, out_row_last};
            prev_last_hs = out_valid && out_ready && out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] t1_data [6];
    logic [7:0] t1_idx  [6];
    logic [7:0] t3_idx  [4];
    logic [7:0] t3_data [4];
    int         pulses;

    initial begin
        t1_data = '{8'h11, 8'h12, 8'h13, 8'h15, 8'h16, 8'h17};
        t1_idx  = '{8'h10, 8'h11, 8'h12, 8'h14, 8'h15, 8'h16};
        t3_idx  = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        t3_data = '{8'hFF, 8'h00, 8'h01, 8'h02};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", 32'({busy, done, gb_wr_en, gb_index, gb_data_in, out_valid,
                                   out_data, out_last, out_row_last}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic tile, full throughput
        out_ready = 1'b1;
        start_tile(8'h10, 4'd2, 4'd3, 4'd4);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc <= 6) check("t1_index", 32'(gb_index), 32'(t1_idx[cyc-1]));
            check("t1_valid", 32'(out_valid), 32'(cyc >= 3 && cyc <= 8));
            if (cyc >= 3 && cyc <= 8) begin
                check("t1_data", 32'(out_data), 32'(t1_data[cyc-3]));
                check("t1_row_last", 32'(out_row_last), 32'(cyc == 5 || cyc == 8));
                check("t1_last", 32'(out_last), 32'(cyc == 8));
            end
            check("t1_done", 32'(done), 32'(cyc == 9));
            check("t1_busy", 32'(busy), 32'(cyc <= 9));
            @(posedge clk); #1;
        end
        check("t1_model_drained", 32'(exp_q.size()), 32'd0);

        // Same tile with pseudo-random backpressure
        start_tile(8'h10, 4'd2, 4'd3, 4'd4);
        rand_mode = 1'b1;
        run_count(80, pulses);
        rand_mode = 1'b0;
        out_ready = 1'b1;
        check("t2_done_pulses", 32'(pulses), 32'd1);
        check("t2_model_drained", 32'(exp_q.size()), 32'd0);
        check("t2_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Address wrap past the top of the GB
        start_tile(8'hFE, 4'd1, 4'd4, 4'd0);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (cyc <= 4) check("t3_index", 32'(gb_index), 32'(t3_idx[cyc-1]));
            if (cyc >= 3 && cyc <= 6) check("t3_data", 32'(out_data), 32'(t3_data[cyc-3]));
            check("t3_done", 32'(done), 32'(cyc == 7));
            @(posedge clk); #1;
        end

        // Empty tiles: rows=0 then cols=0
        for (int k = 0; k < 2; k++) begin
            pulses = 0;
            start_tile(8'h80, (k == 0) ? 4'd0 : 4'd2, (k == 0) ? 4'd3 : 4'd0, 4'd1);
            for (int cyc = 1; cyc <= 6; cyc++) begin
                @(negedge clk);
                check("t4_no_valid", 32'(out_valid), 32'd0);
                check("t4_index_held", 32'(gb_index), 32'h01);
                if (done) pulses++;
                @(posedge clk); #1;
            end
            check("t4_done_pulses", 32'(pulses), 32'd1);
        end

        // Mid-tile start ignored, then reset abort after the 2nd element
        start_tile(8'h10, 4'd2, 4'd3, 4'd4);
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1; base = 8'h40; rows = 4'd1; cols = 4'd1;
        @(negedge clk);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_outputs", 32'({busy, done, gb_wr_en, gb_index, gb_data_in, out_valid,
                                      out_data, out_last, out_row_last}), 32'd0);
        check("t5_consumed_before_rst", 32'(exp_q.size()), 32'd4);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start_tile(8'h10, 4'd2, 4'd3, 4'd4);
        run_count(14, pulses);
        check("t5_done_pulses", 32'(pulses), 32'd1);
        check("t5_model_drained", 32'(exp_q.size()), 32'd0);

        // Single element held under backpressure
        out_ready = 1'b0;
        start_tile(8'h33, 4'd1, 4'd1, 4'd2);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (cyc == 8) out_ready = 1'b1;
            @(negedge clk);
            if (cyc >= 3 && cyc <= 8) begin
                check("t6_valid", 32'(out_valid), 32'd1);
                check("t6_tags", 32'({out_last, out_row_last}), 32'd3);
                check("t6_data", 32'(out_data), 32'h34);
            end
            check("t6_done", 32'(done), 32'(cyc == 9));
            @(posedge clk); #1;
        end
        check("t6_model_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gbuf_tile_reader.md
Name: gbuf_tile_reader

Overview:
- Read initiator for the single-port global buffer (GB). Fetches a 2-D tile in row-major order: rows x cols elements, from base_addr, with a row stride.
- Streams the fetched elements to a downstream consumer (systolic array feeder) over a valid/ready interface.
- Drives the GB's wr_en/index/data_in port and absorbs the GB's 1-cycle registered read latency with a 2-entry output FIFO, so it sustains 1 element/cycle under full throughput and loses no data under backpressure.

Parameters:
- ADDR_BITS, 8, GB address width.
- DATA_BITS, 8, GB word width.
- DIM_BITS, 4, width of the rows, cols and stride fields.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  start request; sampled only in IDLE
- base_addr  in  ADDR_BITS  tile base address
- rows  in  DIM_BITS  tile row count
- cols  in  DIM_BITS  tile column count
- stride  in  DIM_BITS  address distance between row starts
- busy  out  1  high from start acceptance until the done cycle, inclusive
- done  out  1  1-cycle pulse after the last element handshakes
- gb_wr_en  out  1  GB write enable; constant 0
- gb_index  out  ADDR_BITS  GB address
- gb_data_in  out  DATA_BITS  GB write data; constant 0
- gb_data_out  in  DATA_BITS  GB registered read data; valid 1 cycle after gb_index
- out_valid  out  1  stream data valid
- out_ready  in  1  consumer ready
- out_data  out  DATA_BITS  stream data
- out_last  out  1  marks the final element of the tile
- out_row_last  out  1  marks the final element of each row

Behaviour:
- Reset values: busy=0, done=0, gb_wr_en=0, gb_index=0, gb_data_in=0, out_valid=0, out_data=0, out_last=0, out_row_last=0. FSM=IDLE, FIFO empty, in-flight flag clear.
- Reset asserted mid-tile aborts immediately. No done pulse; state returns to IDLE.
- On start in IDLE, latch base_addr, rows, cols and stride.
- FSM states:
  - IDLE: waits for start. If rows==0 or cols==0, go to DONE (no reads issued); otherwise go to ISSUE.
  - ISSUE: issues reads. Moves to DRAIN after the final read is issued.
  - DRAIN: waits until the in-flight read has landed and the FIFO is empty, then goes to DONE.
  - DONE: asserts done=1 for one cycle, then returns to IDLE.
- start is ignored while not in IDLE, including during the DONE cycle.
- Address generation:
  - Element (r,c) reads address (base + r*stride + c) mod 2^ADDR_BITS.
  - Computed incrementally: a row-start register plus a column counter. Wrap-around past the top address is silent.
- Issue rule: a read is issued in a cycle iff state==ISSUE and (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready.
  - Issuing means gb_index presents the address for that cycle.
  - inflight is set for the following cycle; the returning gb_data_out is pushed into the FIFO at the end of that cycle.
- When no read is issued, gb_index holds its last value. This is harmless because the block never writes.
- Tag pipeline: out_row_last and out_last are generated at issue time (c==cols-1; and additionally r==rows-1 for out_last). They travel with the data through the in-flight stage and the FIFO.
- Latency: with start high in cycle 0, gb_index=base in cycle 1, the push happens at the end of cycle 2, and out_valid=1 in cycle 3.
- Throughput: with out_ready held high, one element per cycle and no bubbles after the first.
- Handshake rules:
  - out_data, out_last and out_row_last are stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a handshake.
- done asserts the cycle after the last handshake (out_last & out_ready). busy falls the cycle after done.
- Simultaneous push and pop on the FIFO are allowed at any count. The FIFO never overflows, by the issue rule.

Test Plan:
- Reset init (mem[i]=i+1, truncated to DATA_BITS); base=0x10, rows=2, cols=3, stride=4, out_ready=1 -> out_data 0x11,0x12,0x13,0x15,0x16,0x17 in consecutive cycles 3..8. out_row_last on the 3rd and 6th elements, out_last on the 6th. done in cycle 9.
- Same tile with out_ready toggling pseudo-randomly (seeded) -> identical data sequence, no loss or duplication, outputs stable while stalled, gb_wr_en always 0.
- Wrap: base=0xFE, rows=1, cols=4 -> gb_index FE,FF,00,01; out_data 0xFF,0x00,0x01,0x02.
- rows=0 (or cols=0) -> no out_valid, gb_index unchanged, done pulses exactly once.
- start pulsed again mid-tile -> ignored; rst asserted after the 2nd element -> all outputs at reset values next cycle. A new start then runs the full tile correctly.
- Single element (rows=1, cols=1) with out_ready=0 for 5 cycles -> out_valid held with out_last=out_row_last=1; done the cycle after the ready handshake.
